// File: rtl/keen_operand_fetch.sv
// Operand-fetch stage: busy-bit scoreboard with RAW/WAW stalls, same-edge writeback
// bypass, and a one-entry output register toward execute.
`timescale 1ns/1ps
module keen_operand_fetch #(
  parameter  int REGISTERS    = 32,
  parameter  int WORD_SIZE    = 32,
  localparam int ADDRESS_SIZE = $clog2(REGISTERS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_SIZE-1:0] in_rs1,
  input  logic [ADDRESS_SIZE-1:0] in_rs2,
  input  logic [ADDRESS_SIZE-1:0] in_rd,
  input  logic                    in_rd_write,
  output logic [ADDRESS_SIZE-1:0] rf_read_address_0,
  output logic [ADDRESS_SIZE-1:0] rf_read_address_1,
  input  logic [WORD_SIZE-1:0]    rf_read_data_0,
  input  logic [WORD_SIZE-1:0]    rf_read_data_1,
  input  logic                    wb_valid,
  input  logic [ADDRESS_SIZE-1:0] wb_rd,
  input  logic [WORD_SIZE-1:0]    wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_SIZE-1:0]    out_rs1_data,
  output logic [WORD_SIZE-1:0]    out_rs2_data,
  output logic [ADDRESS_SIZE-1:0] out_rd,
  output logic                    out_rd_write,
  output logic [REGISTERS-1:0]    busy,
  output logic [1:0]              dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and payload stays stable while valid & !ready.

  typedef enum logic [1:0] {EMPTY = 2'd0, READ = 2'd1, HOLD = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [REGISTERS-1:0]    busy_q, busy_d;
  logic [ADDRESS_SIZE-1:0] rd_q, rd_d;
  logic                    rd_write_q, rd_write_d;
  logic                    byp0_q, byp0_d, byp1_q, byp1_d;
  logic [WORD_SIZE-1:0]    byp0_data_q, byp0_data_d, byp1_data_q, byp1_data_d;
  logic [WORD_SIZE-1:0]    hold0_q, hold0_d, hold1_q, hold1_d;

  logic                    clr_rs1, clr_rs2, clr_rd;
  logic                    hit_rs1, hit_rs2, hit_rd;
  logic                    hazard, accept;
  logic [WORD_SIZE-1:0]    sel0, sel1;

  // A busy register being written back this very cycle no longer blocks.
  assign clr_rs1 = wb_valid && (wb_rd == in_rs1);
  assign clr_rs2 = wb_valid && (wb_rd == in_rs2);
  assign clr_rd  = wb_valid && (wb_rd == in_rd);
  assign hit_rs1 = (in_rs1 != '0) && busy_q[in_rs1] && !clr_rs1;
  assign hit_rs2 = (in_rs2 != '0) && busy_q[in_rs2] && !clr_rs2;
  assign hit_rd  = (in_rd  != '0) && busy_q[in_rd]  && !clr_rd;
  assign hazard  = hit_rs1 || hit_rs2 || (in_rd_write && hit_rd);

  assign in_ready = ((state_q == EMPTY) || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  assign rf_read_address_0 = in_rs1;
  assign rf_read_address_1 = in_rs2;

  // The register file's registered read misses a same-edge write; bypass covers it.
  assign sel0 = byp0_q ? byp0_data_q : rf_read_data_0;
  assign sel1 = byp1_q ? byp1_data_q : rf_read_data_1;

  assign out_valid    = (state_q != EMPTY);
  assign out_rs1_data = (state_q == READ) ? sel0 : hold0_q;
  assign out_rs2_data = (state_q == READ) ? sel1 : hold1_q;
  assign out_rd       = rd_q;
  assign out_rd_write = rd_write_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    rd_write_d  = rd_write_q;
    byp0_d      = byp0_q;
    byp1_d      = byp1_q;
    byp0_data_d = byp0_data_q;
    byp1_data_d = byp1_data_q;
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;

    case (state_q)
      EMPTY: if (accept) state_d = READ;
      READ: begin
        if (accept) begin
          state_d = READ;
        end else if (out_ready) begin
          state_d = EMPTY;
        end else begin
          // Read data is only valid for one cycle, so freeze it for the stall.
          state_d = HOLD;
          hold0_d = sel0;
          hold1_d = sel1;
        end
      end
      HOLD: begin
        if (accept)         state_d = READ;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      rd_d        = in_rd;
      rd_write_d  = in_rd_write;
      byp0_d      = clr_rs1 && (in_rs1 != '0);
      byp1_d      = clr_rs2 && (in_rs2 != '0);
      byp0_data_d = wb_data;
      byp1_data_d = wb_data;
    end
  end

  // Clear first, then set, so a same-edge set of the same bit wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (accept && in_rd_write && (in_rd != '0)) busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      busy_q      <= '0;
      rd_q        <= '0;
      rd_write_q  <= 1'b0;
      byp0_q      <= 1'b0;
      byp1_q      <= 1'b0;
      byp0_data_q <= '0;
      byp1_data_q <= '0;
      hold0_q     <= '0;
      hold1_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      rd_q        <= rd_d;
      rd_write_q  <= rd_write_d;
      byp0_q      <= byp0_d;
      byp1_q      <= byp1_d;
      byp0_data_q <= byp0_data_d;
      byp1_data_q <= byp1_data_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
    end
  end

endmodule

// File: tb/tb_keen_operand_fetch.sv
// Bench for keen_operand_fetch: directed vector table, mid-operation reset,
// then random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_keen_operand_fetch;

  localparam int W  = 32;
  localparam int A  = 5;
  localparam int NR = 32;
  localparam int EW = 2*W + A + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_rd_write;
  logic [A-1:0]  in_rs1, in_rs2, in_rd;
  logic [A-1:0]  rf_read_address_0, rf_read_address_1;
  logic [W-1:0]  rf_read_data_0 = '0;
  logic [W-1:0]  rf_read_data_1 = '0;
  logic          wb_valid;
  logic [A-1:0]  wb_rd;
  logic [W-1:0]  wb_data;
  logic          out_valid, out_ready, out_rd_write;
  logic [W-1:0]  out_rs1_data, out_rs2_data;
  logic [A-1:0]  out_rd;
  logic [NR-1:0] busy;
  logic [1:0]    dbg_state;

  keen_operand_fetch #(.REGISTERS(NR), .WORD_SIZE(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_write(in_rd_write),
    .rf_read_address_0(rf_read_address_0), .rf_read_address_1(rf_read_address_1),
    .rf_read_data_0(rf_read_data_0), .rf_read_data_1(rf_read_data_1),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_write(out_rd_write),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Register file: registered read of the old value, write on the same edge, x0 hardwired.
  logic [W-1:0] rf_mem [NR] = '{default: '0};
  always @(posedge clk) begin
    rf_read_data_0 <= rf_mem[rf_read_address_0];
    rf_read_data_1 <= rf_mem[rf_read_address_1];
    if (wb_valid && wb_rd != '0) rf_mem[wb_rd] <= wb_data;
  end

  // scoreboard / reference model
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic [NR-1:0] m_busy = '0;
  logic [W-1:0]  m_arch [NR] = '{default: '0};

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [A-1:0] r);
    return (r != 0) && m_busy[r] && !(wb_valid && wb_rd == r);
  endfunction

  function automatic logic m_in_ready();
    logic haz;
    haz = m_hit(in_rs1) || m_hit(in_rs2) || (in_rd_write && m_hit(in_rd));
    return ((exp_q.size() == 0) || out_ready) && !haz;
  endfunction

  // Newest architectural value of r as of this edge, including its writeback.
  function automatic logic [W-1:0] m_val(input logic [A-1:0] r);
    if (r == 0) return '0;
    if (wb_valid && wb_rd == r) return wb_data;
    return m_arch[r];
  endfunction

  task automatic model_advance();
    logic acc;
    acc = in_valid && m_in_ready();
    if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    if (acc) exp_q.push_back({m_val(in_rs1), m_val(in_rs2), in_rd, in_rd_write});
    if (wb_valid) m_busy[wb_rd] = 1'b0;
    if (acc && in_rd_write && in_rd != 0) m_busy[in_rd] = 1'b1;
    if (wb_valid && wb_rd != 0) m_arch[wb_rd] = wb_data;
  endtask

  task automatic model_check();
    chk("in_ready", in_ready, m_in_ready());
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("busy", busy, m_busy);
    if (exp_q.size() != 0)
      chk("out_payload", {out_rs1_data, out_rs2_data, out_rd, out_rd_write}, exp_q[0]);
  endtask

  // driver tasks
  task automatic drive_in(input logic v, input logic [A-1:0] rs1, input logic [A-1:0] rs2,
                          input logic [A-1:0] rd, input logic rdw);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_write = rdw;
  endtask

  task automatic drive_wb(input logic v, input logic [A-1:0] rd, input logic [W-1:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  // vector table
  typedef struct {
    logic iv; logic [A-1:0] rs1, rs2, rd; logic rdw;
    logic wbv; logic [A-1:0] wbrd; logic [W-1:0] wbd; logic ordy;
    logic e_irdy, e_ovld; logic [W-1:0] e_op1, e_op2; logic [NR-1:0] e_busy; logic [1:0] e_state;
  } vec_t;

  function automatic vec_t mk(input logic iv, input int rs1, input int rs2, input int rd,
                              input logic rdw, input logic wbv, input int wbrd, input logic [W-1:0] wbd,
                              input logic ordy, input logic e_irdy, input logic e_ovld,
                              input logic [W-1:0] e_op1, input logic [W-1:0] e_op2,
                              input logic [NR-1:0] e_busy, input logic [1:0] e_state);
    vec_t v;
    v.iv = iv; v.rs1 = A'(rs1); v.rs2 = A'(rs2); v.rd = A'(rd); v.rdw = rdw;
    v.wbv = wbv; v.wbrd = A'(wbrd); v.wbd = wbd; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_op1 = e_op1; v.e_op2 = e_op2;
    v.e_busy = e_busy; v.e_state = e_state;
    return v;
  endfunction

  localparam int NV = 27;
  vec_t vec [NV];

  initial begin
    // Back-to-back independent pair after preloading x1=5, x2=7
    vec[0]  = mk(0,0,0,0,0, 1,1,32'h5,        1, 1,0,0,0,32'h00,0);
    vec[1]  = mk(0,0,0,0,0, 1,2,32'h7,        1, 1,0,0,0,32'h00,0);
    vec[2]  = mk(1,1,2,3,1, 0,0,0,            1, 1,0,0,0,32'h00,0);
    vec[3]  = mk(1,2,1,4,1, 0,0,0,            1, 1,1,5,7,32'h08,1);
    vec[4]  = mk(0,0,0,0,0, 0,0,0,            1, 1,1,7,5,32'h18,1);
    vec[5]  = mk(0,0,0,0,0, 0,0,0,            1, 1,0,0,0,32'h18,0);
    // RAW stall on x5 released by its writeback, value arrives via bypass
    vec[6]  = mk(1,0,0,5,1, 0,0,0,            1, 1,0,0,0,32'h18,0);
    vec[7]  = mk(1,5,1,6,0, 0,0,0,            1, 0,1,0,0,32'h38,1);
    vec[8]  = mk(1,5,1,6,0, 0,0,0,            1, 0,0,0,0,32'h38,0);
    vec[9]  = mk(1,5,1,6,0, 1,5,32'hDEADBEEF, 1, 1,0,0,0,32'h38,0);
    vec[10] = mk(0,0,0,0,0, 1,3,32'h33,       1, 1,1,32'hDEADBEEF,5,32'h18,1);
    vec[11] = mk(0,0,0,0,0, 1,4,32'h44,       1, 1,0,0,0,32'h10,0);
    // Backpressure: three stalled cycles, operands frozen while rf read data moves on
    vec[12] = mk(1,3,4,7,1, 0,0,0,            1, 1,0,0,0,32'h00,0);
    vec[13] = mk(1,1,2,8,0, 0,0,0,            0, 0,1,32'h33,32'h44,32'h80,1);
    vec[14] = mk(1,1,2,8,0, 0,0,0,            0, 0,1,32'h33,32'h44,32'h80,2);
    vec[15] = mk(1,1,2,8,0, 0,0,0,            0, 0,1,32'h33,32'h44,32'h80,2);
    vec[16] = mk(1,1,2,8,0, 0,0,0,            1, 1,1,32'h33,32'h44,32'h80,2);
    vec[17] = mk(0,0,0,0,0, 0,0,0,            1, 1,1,5,7,32'h80,1);
    // Set/clear collision on x6: set wins, no stall
    vec[18] = mk(1,0,0,6,1, 0,0,0,            1, 1,0,0,0,32'h80,0);
    vec[19] = mk(1,0,0,6,1, 1,6,32'h66,       1, 1,1,0,0,32'hC0,1);
    vec[20] = mk(0,0,0,0,0, 0,0,0,            1, 1,1,0,0,32'hC0,1);
    // r0: write to x0 with a writeback to x0 in the same cycle
    vec[21] = mk(1,0,1,0,1, 1,0,32'h12345678, 1, 1,0,0,0,32'hC0,0);
    vec[22] = mk(0,0,0,0,0, 0,0,0,            1, 1,1,0,5,32'hC0,1);
    // Build busy=0xF0 and park in HOLD ahead of the mid-operation reset
    vec[23] = mk(1,0,0,4,1, 0,0,0,            1, 1,0,0,0,32'hC0,0);
    vec[24] = mk(1,1,2,5,1, 0,0,0,            1, 1,1,0,0,32'hD0,1);
    vec[25] = mk(0,0,0,0,0, 0,0,0,            0, 0,1,5,7,32'hF0,1);
    vec[26] = mk(0,0,0,0,0, 0,0,0,            0, 0,1,5,7,32'hF0,2);

    reset = 1'b1;
    drive_in(0, 0, 0, 0, 0);
    drive_wb(0, 0, '0);
    out_ready = 1'b1;
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, '0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_rd", {out_rd, out_rd_write}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive_in(vec[i].iv, vec[i].rs1, vec[i].rs2, vec[i].rd, vec[i].rdw);
      drive_wb(vec[i].wbv, vec[i].wbrd, vec[i].wbd);
      out_ready = vec[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, vec[i].e_irdy);
      chk($sformatf("v%0d_out_valid", i), out_valid, vec[i].e_ovld);
      chk($sformatf("v%0d_busy", i), busy, vec[i].e_busy);
      chk($sformatf("v%0d_state", i), dbg_state, vec[i].e_state);
      if (vec[i].e_ovld)
        chk($sformatf("v%0d_operands", i), {out_rs1_data, out_rs2_data}, {vec[i].e_op1, vec[i].e_op2});
      model_advance();
    end

    // Reset in HOLD with busy=0xF0 takes effect before any clock edge
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_busy", busy, '0);
    chk("midreset_state", dbg_state, 2'd0);
    chk("midreset_in_ready", in_ready, 1'b1);
    drive_in(0, 0, 0, 0, 0);
    drive_wb(0, 0, '0);
    exp_q.delete();
    m_busy = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Random traffic on x0..x7 to provoke hazards, collisions and backpressure
    for (int c = 0; c < 600; c++) begin
      if (c != 0) @(negedge clk);
      drive_in($urandom_range(0, 3) != 0, A'($urandom_range(0, 7)), A'($urandom_range(0, 7)),
               A'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      drive_wb($urandom_range(0, 1) == 1, A'($urandom_range(0, 7)), $urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      model_check();
      model_advance();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
